// File: rtl/image_relief_filter.sv
// Emboss/relief filter: horizontal, vertical or diagonal neighbour difference plus
// offset with signed saturation, or bypass. Fixed 3-cycle latency on data and syncs.
module image_relief_filter #(
    parameter int DW     = 8,
    parameter int MAX_W  = 1024,
    parameter int OFFSET = 50
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] in_data,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    output logic [DW-1:0] out_data,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de
);

    localparam int CW = $clog2(MAX_W + 1);
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CW-1:0]        MAX_C = CW'(MAX_W);
    localparam logic signed [DW+1:0] OFF_S = (DW+2)'(OFFSET);

    typedef enum logic [1:0] {
        MODE_H   = 2'd0,
        MODE_V   = 2'd1,
        MODE_D   = 2'd2,
        MODE_BYP = 2'd3
    } mode_t;

    // input-side state
    logic          vsync_d, de_d, line_nz;
    mode_t         mode_q, mode_eff;
    logic [CW-1:0] col;
    logic [DW-1:0] prev_pix;
    logic          vs_rise, row0, c_over, c_zero;
    logic [AW-1:0] addr;

    // line buffer
    logic [DW-1:0] mem [MAX_W];
    logic [DW-1:0] rd_data;

    // stage 1
    logic          v1, de1, hs1, vs1, c0_1, cover_1, row0_1;
    mode_t         mode1;
    logic [DW-1:0] x1, hn1, diag_prev, n_sel;

    // stage 2
    logic          v2, de2, hs2, vs2;
    mode_t         mode2;
    logic [DW-1:0] x2, n2, sat;
    logic signed [DW+1:0] diff;

    always_comb begin
        vs_rise  = vsync & ~vsync_d;
        mode_eff = vs_rise ? mode_t'(mode) : mode_q;
        row0     = vs_rise | ~line_nz;
        c_over   = (col >= MAX_C);
        c_zero   = (col == '0);
        addr     = col[AW-1:0];
    end

    // Read-before-write falls out of the non-blocking update: rd_data gets the old word.
    always_ff @(posedge clk) begin
        if (de && !c_over) begin
            mem[addr] <= in_data;
            rd_data   <= mem[addr];
        end
    end

    always_comb begin
        n_sel = x1;
        if (de1) begin
            case (mode1)
                MODE_H:  n_sel = c0_1 ? x1 : hn1;
                MODE_V:  n_sel = (row0_1 || cover_1) ? x1 : rd_data;
                MODE_D:  n_sel = (row0_1 || c0_1 || cover_1) ? x1 : diag_prev;
                default: n_sel = x1;
            endcase
        end
    end

    always_comb begin
        diff = $signed({2'b00, x2}) - $signed({2'b00, n2}) + OFF_S;
        if (diff[DW+1])
            sat = '0;
        else if (diff[DW])
            sat = '1;
        else
            sat = diff[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d   <= 1'b0;
            de_d      <= 1'b0;
            line_nz   <= 1'b0;
            mode_q    <= MODE_H;
            col       <= '0;
            prev_pix  <= '0;
            v1        <= 1'b0;
            de1       <= 1'b0;
            hs1       <= 1'b0;
            vs1       <= 1'b0;
            c0_1      <= 1'b0;
            cover_1   <= 1'b0;
            row0_1    <= 1'b0;
            mode1     <= MODE_H;
            x1        <= '0;
            hn1       <= '0;
            diag_prev <= '0;
            v2        <= 1'b0;
            de2       <= 1'b0;
            hs2       <= 1'b0;
            vs2       <= 1'b0;
            mode2     <= MODE_H;
            x2        <= '0;
            n2        <= '0;
            out_data  <= '0;
            o_hsync   <= 1'b0;
            o_vsync   <= 1'b0;
            o_de      <= 1'b0;
        end else begin
            vsync_d <= vsync;
            de_d    <= de;
            mode_q  <= mode_eff;
            if (vs_rise)
                line_nz <= 1'b0;
            else if (de_d && !de)
                line_nz <= 1'b1;
            if (!de)
                col <= '0;
            else if (!c_over)
                col <= col + 1'b1;
            if (de)
                prev_pix <= in_data;

            v1      <= 1'b1;
            de1     <= de;
            hs1     <= hsync;
            vs1     <= vsync;
            c0_1    <= c_zero;
            cover_1 <= c_over;
            row0_1  <= row0;
            mode1   <= mode_eff;
            x1      <= in_data;
            hn1     <= prev_pix;
            // holds the buffer word of column c-1 for the diagonal neighbour
            if (de1)
                diag_prev <= rd_data;

            v2    <= v1;
            de2   <= de1;
            hs2   <= hs1;
            vs2   <= vs1;
            mode2 <= mode1;
            x2    <= x1;
            n2    <= n_sel;

            out_data <= !v2 ? '0 : ((mode2 == MODE_BYP) ? x2 : sat);
            o_hsync  <= hs2;
            o_vsync  <= vs2;
            o_de     <= de2;
        end
    end

endmodule
